// File: rtl/coef_loader.sv
// Feeds 256 coefficients (two per 32-bit word) into the NTT/INTT core's input RAM,
// reducing each mod Q, then releases start and waits for the core's done.
module coef_loader #(
  parameter int Q = 3329,
  parameter int N = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic        go_mode,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        core_done,
  output logic        start,
  output logic        we,
  output logic        mode,
  output logic [7:0]  address_ina,
  output logic [7:0]  address_inb,
  output logic [15:0] data_ina,
  output logic [15:0] data_inb,
  output logic        busy,
  output logic        ld_done,
  output logic        range_err
);

  localparam int KW = $clog2(N / 2);
  localparam logic [KW-1:0] K_LAST = KW'(N / 2 - 1);
  localparam logic [11:0] QV = 12'(Q);

  typedef enum logic [2:0] {IDLE, LOAD, KICK, RUN, FIN} state_t;

  state_t        state;
  logic [KW-1:0] k;
  logic [11:0]   v_even;
  logic [11:0]   v_odd;
  logic [15:0]   red_even;
  logic [15:0]   red_odd;
  logic          out_of_range;

  // Only the low 12 bits are reduced; a single subtraction suffices since 4095 < 2Q.
  always_comb begin
    v_even       = in_data[11:0];
    v_odd        = in_data[27:16];
    red_even     = {4'b0, (v_even >= QV) ? (v_even - QV) : v_even};
    red_odd      = {4'b0, (v_odd >= QV) ? (v_odd - QV) : v_odd};
    out_of_range = (in_data[15:12] != 4'b0) || (in_data[31:28] != 4'b0);
  end

  assign in_ready = (state == LOAD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      k           <= '0;
      start       <= 1'b0;
      we          <= 1'b0;
      mode        <= 1'b0;
      address_ina <= 8'd0;
      address_inb <= 8'd0;
      data_ina    <= 16'd0;
      data_inb    <= 16'd0;
      busy        <= 1'b0;
      ld_done     <= 1'b0;
      range_err   <= 1'b0;
    end else begin
      we      <= 1'b0;
      ld_done <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            state     <= LOAD;
            mode      <= go_mode;
            k         <= '0;
            range_err <= 1'b0;
            start     <= 1'b1;
            busy      <= 1'b1;
          end
        end
        LOAD: begin
          if (in_valid) begin
            we          <= 1'b1;
            address_ina <= 8'({k, 1'b0});
            address_inb <= 8'({k, 1'b1});
            data_ina    <= red_even;
            data_inb    <= red_odd;
            if (out_of_range) range_err <= 1'b1;
            // The last pair leaves k at its final value rather than wrapping.
            if (k == K_LAST) begin
              state <= KICK;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        KICK: begin
          state       <= RUN;
          start       <= 1'b0;
          address_ina <= 8'd0;
          address_inb <= 8'd0;
        end
        RUN: begin
          if (core_done) begin
            state   <= FIN;
            ld_done <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coef_loader.sv
// Directed testbench for coef_loader: ramp, reduction, throttling, handshake,
// mid-load reset and spurious control inputs.
module tb_coef_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        go = 1'b0;
  logic        go_mode = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic        core_done = 1'b0;
  logic        start, we, mode, busy, ld_done, range_err;
  logic [7:0]  address_ina, address_inb;
  logic [15:0] data_ina, data_inb;

  int checks = 0;
  int passed = 0;

  coef_loader dut (
    .clk(clk), .rst(rst), .go(go), .go_mode(go_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .core_done(core_done), .start(start), .we(we), .mode(mode),
    .address_ina(address_ina), .address_inb(address_inb),
    .data_ina(data_ina), .data_inb(data_inb),
    .busy(busy), .ld_done(ld_done), .range_err(range_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [63:0] obs;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    obs = {start, we, mode, address_ina, address_inb, data_ina, data_inb, busy, ld_done, range_err, in_ready};
    checks++; if (obs !== 64'd0) $display("[TB] FAIL reset_outputs: got %h expected 0", obs); else passed++;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_ramp();
    logic [48:0] obs, exp;
    int pulses = 0;
    go = 1'b1; go_mode = 1'b0;
    tick();
    go = 1'b0;
    checks++; if ({busy, start, in_ready, mode, we} !== 5'b11100) $display("[TB] FAIL ramp_enter: got %b expected 11100", {busy, start, in_ready, mode, we}); else passed++;
    for (int i = 0; i < 128; i++) begin
      in_valid = 1'b1;
      in_data = {16'(2 * i + 1), 16'(2 * i)};
      tick();
      if (we) pulses++;
      obs = {we, address_ina, address_inb, data_ina, data_inb};
      exp = {1'b1, 8'(2 * i), 8'(2 * i + 1), 16'(2 * i), 16'(2 * i + 1)};
      checks++; if (obs !== exp) $display("[TB] FAIL ramp_write[%0d]: got %h expected %h", i, obs, exp); else passed++;
      checks++; if ({start, in_ready} !== {1'b1, (i < 127)}) $display("[TB] FAIL ramp_ready[%0d]: got %b expected %b", i, {start, in_ready}, {1'b1, (i < 127)}); else passed++;
    end
    in_valid = 1'b0;
    tick();
    checks++; if ({start, we, address_ina, address_inb, busy, mode, range_err} !== {2'b00, 16'd0, 3'b100}) $display("[TB] FAIL ramp_run: got %h expected %h", {start, we, address_ina, address_inb, busy, mode, range_err}, {2'b00, 16'd0, 3'b100}); else passed++;
    checks++; if (pulses !== 128) $display("[TB] FAIL ramp_pulses: got %0d expected 128", pulses); else passed++;
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    checks++; if ({ld_done, busy} !== 2'b11) $display("[TB] FAIL ramp_fin: got %b expected 11", {ld_done, busy}); else passed++;
    tick();
    checks++; if ({ld_done, busy} !== 2'b00) $display("[TB] FAIL ramp_idle: got %b expected 00", {ld_done, busy}); else passed++;
  endtask

  task automatic test_reduction();
    go = 1'b1; go_mode = 1'b0;
    tick();
    go = 1'b0;
    in_valid = 1'b1;
    in_data = {16'h1FFF, 16'h0D01};
    tick();
    checks++; if ({data_ina, data_inb} !== {16'd0, 16'd766}) $display("[TB] FAIL red_word0: got %0d,%0d expected 0,766", data_ina, data_inb); else passed++;
    checks++; if (range_err !== 1'b1) $display("[TB] FAIL red_err_set: got %b expected 1", range_err); else passed++;
    in_data = {16'h0D00, 16'h0D02};
    tick();
    checks++; if ({data_ina, data_inb} !== {16'd1, 16'd3328}) $display("[TB] FAIL red_word1: got %0d,%0d expected 1,3328", data_ina, data_inb); else passed++;
    in_data = {16'h0FFF, 16'h0000};
    tick();
    checks++; if ({data_ina, data_inb} !== {16'd0, 16'd766}) $display("[TB] FAIL red_word2: got %0d,%0d expected 0,766", data_ina, data_inb); else passed++;
    in_data = 32'd0;
    repeat (125) tick();
    in_valid = 1'b0;
    tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    checks++; if ({ld_done, range_err} !== 2'b11) $display("[TB] FAIL red_err_fin: got %b expected 11", {ld_done, range_err}); else passed++;
    tick();
  endtask

  task automatic test_throttle();
    logic [16:0] obs, exp;
    logic [7:0]  prev_a = 8'd0, prev_b = 8'd0;
    int w = 0;
    int c = 0;
    go = 1'b1; go_mode = 1'b0;
    tick();
    go = 1'b0;
    checks++; if (range_err !== 1'b0) $display("[TB] FAIL thr_err_clear: got %b expected 0", range_err); else passed++;
    while (w < 128) begin
      in_valid = (c % 3 == 0);
      in_data = {16'(2 * w + 1), 16'(2 * w)};
      tick();
      if (c % 3 == 0) begin
        exp = {1'b1, 8'(2 * w), 8'(2 * w + 1)};
        prev_a = 8'(2 * w); prev_b = 8'(2 * w + 1);
        w++;
      end else begin
        exp = {1'b0, prev_a, prev_b};
      end
      obs = {we, address_ina, address_inb};
      checks++; if (obs !== exp) $display("[TB] FAIL thr_cycle[%0d]: got %h expected %h", c, obs, exp); else passed++;
      c++;
    end
    in_valid = 1'b0;
    core_done = 1'b1;
    tick();
    checks++; if ({ld_done, start, busy} !== 3'b001) $display("[TB] FAIL thr_kick_ignore_done: got %b expected 001", {ld_done, start, busy}); else passed++;
    tick();
    core_done = 1'b0;
    checks++; if (ld_done !== 1'b1) $display("[TB] FAIL thr_done_on_entry: got %b expected 1", ld_done); else passed++;
    tick();
    checks++; if (busy !== 1'b0) $display("[TB] FAIL thr_idle: got %b expected 0", busy); else passed++;
  endtask

  task automatic test_handshake();
    int pulses = 0;
    go = 1'b1; go_mode = 1'b1;
    tick();
    go = 1'b0; go_mode = 1'b0;
    for (int i = 0; i < 128; i++) begin
      in_valid = 1'b1;
      in_data = {16'(i), 16'(i)};
      tick();
      checks++; if ({mode, we, address_inb} !== {2'b11, 8'(2 * i + 1)}) $display("[TB] FAIL hs_load[%0d]: got %h expected %h", i, {mode, we, address_inb}, {2'b11, 8'(2 * i + 1)}); else passed++;
    end
    in_valid = 1'b0;
    tick();
    for (int i = 1; i < 40; i++) begin
      tick();
      if (ld_done) pulses++;
      checks++; if ({busy, mode, start} !== 3'b110) $display("[TB] FAIL hs_run[%0d]: got %b expected 110", i, {busy, mode, start}); else passed++;
    end
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    if (ld_done) pulses++;
    checks++; if ({ld_done, busy, mode} !== 3'b111) $display("[TB] FAIL hs_fin: got %b expected 111", {ld_done, busy, mode}); else passed++;
    tick();
    if (ld_done) pulses++;
    checks++; if ({ld_done, busy, mode} !== 3'b001) $display("[TB] FAIL hs_idle: got %b expected 001", {ld_done, busy, mode}); else passed++;
    checks++; if (pulses !== 1) $display("[TB] FAIL hs_pulses: got %0d expected 1", pulses); else passed++;
  endtask

  task automatic test_midload_reset();
    logic [63:0] obs;
    go = 1'b1; go_mode = 1'b1;
    tick();
    go = 1'b0;
    for (int i = 0; i < 50; i++) begin
      in_valid = 1'b1;
      in_data = {16'(2 * i + 1), 16'(2 * i)};
      tick();
    end
    rst = 1'b0;
    #1;
    obs = {start, we, mode, address_ina, address_inb, data_ina, data_inb, busy, ld_done, range_err, in_ready};
    checks++; if (obs !== 64'd0) $display("[TB] FAIL mid_reset_outputs: got %h expected 0", obs); else passed++;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    tick();
    go = 1'b1; go_mode = 1'b0;
    tick();
    go = 1'b0;
    for (int i = 0; i < 128; i++) begin
      in_valid = 1'b1;
      in_data = {16'(2 * i + 1), 16'(2 * i)};
      tick();
      checks++; if ({we, mode, address_ina, data_inb} !== {2'b10, 8'(2 * i), 16'(2 * i + 1)}) $display("[TB] FAIL mid_reload[%0d]: got %h expected %h", i, {we, mode, address_ina, data_inb}, {2'b10, 8'(2 * i), 16'(2 * i + 1)}); else passed++;
    end
    in_valid = 1'b0;
    tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    checks++; if (ld_done !== 1'b1) $display("[TB] FAIL mid_reload_done: got %b expected 1", ld_done); else passed++;
    tick();
  endtask

  task automatic test_spurious();
    go = 1'b1; go_mode = 1'b0;
    tick();
    go = 1'b0;
    for (int i = 0; i < 128; i++) begin
      in_valid = 1'b1;
      in_data = {16'(2 * i + 1), 16'(2 * i)};
      if (i == 20) begin go = 1'b1; go_mode = 1'b1; end
      if (i == 21) core_done = 1'b1;
      tick();
      go = 1'b0; go_mode = 1'b0; core_done = 1'b0;
      if (i == 20 || i == 21) begin
        checks++; if ({we, mode, in_ready, ld_done, busy, address_ina} !== {5'b10101, 8'(2 * i)}) $display("[TB] FAIL spur_load[%0d]: got %h expected %h", i, {we, mode, in_ready, ld_done, busy, address_ina}, {5'b10101, 8'(2 * i)}); else passed++;
      end
    end
    checks++; if ({we, address_inb} !== {1'b1, 8'd255}) $display("[TB] FAIL spur_kick: got %h expected 1ff", {we, address_inb}); else passed++;
    in_valid = 1'b0;
    tick();
    go = 1'b1; go_mode = 1'b1; in_valid = 1'b1;
    tick();
    go = 1'b0; go_mode = 1'b0; in_valid = 1'b0;
    checks++; if ({busy, start, we, mode, in_ready, ld_done} !== 6'b100000) $display("[TB] FAIL spur_run: got %b expected 100000", {busy, start, we, mode, in_ready, ld_done}); else passed++;
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    tick();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if ({busy, we, in_ready, start} !== 4'b0000) $display("[TB] FAIL spur_idle_valid: got %b expected 0000", {busy, we, in_ready, start}); else passed++;
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_reduction();
    test_throttle();
    test_handshake();
    test_midload_reset();
    test_spurious();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
